// File: rtl/lif_pkg.sv
// Shared constants and types for the time-multiplexed 2-4-2 LIF network.
package lif_pkg;

  localparam int STATE_W   = 4;
  localparam int N_NEURONS = 8;
  localparam int IDX_W     = 3;
  localparam int N_HID     = 4;
  localparam int N_OUT     = 2;

  // Neuron index map: 0-1 input, 2-5 hidden, 6-7 output.
  localparam logic [IDX_W-1:0] IDX_IN0  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_IN1  = 3'd1;
  localparam logic [IDX_W-1:0] IDX_HID0 = 3'd2;
  localparam logic [IDX_W-1:0] IDX_OUT0 = 3'd6;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/lif_update.sv
// Shared LIF datapath: leak, integrate, saturate, fire. Purely combinational.
module lif_update
  import lif_pkg::*;
#(
  parameter int LEAK_SHIFT = 1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] current,
  input  logic [STATE_W-1:0] thresh,
  output logic [STATE_W-1:0] next_state,
  output logic               spike
);

  logic [STATE_W-1:0] leaked;
  logic [STATE_W:0]   sum;
  logic [STATE_W-1:0] sat;

  // NOTE: every variable driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    leaked     = state >> LEAK_SHIFT;
    sum        = {1'b0, leaked} + {1'b0, current};
    sat        = sum[STATE_W] ? '1 : sum[STATE_W-1:0];
    spike      = (sat >= thresh);
    // A firing neuron resets; next_state is the value to commit.
    next_state = spike ? '0 : sat;
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// Sequences one shared LIF engine over eight neurons in layer order per timestep.
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter logic [STATE_W-1:0] THRESH     = 4'd8,
  parameter int                 LEAK_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_start,
  input  logic [STATE_W-1:0] cur_a,
  input  logic [STATE_W-1:0] cur_b,
  input  logic               clear,
  output logic               busy,
  output logic               step_done,
  output logic [1:0]         out_spikes,
  output logic [3:0]         hid_spikes,
  output logic [7:0]         step_count
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [STATE_W-1:0] mem_q [N_NEURONS];
  logic [N_NEURONS-1:0] spk_q;
  logic [STATE_W-1:0] cur_a_q, cur_b_q;

  logic [STATE_W-1:0] upd_current;
  logic [STATE_W-1:0] upd_next;
  logic               upd_spike;

  // Each layer's current is built from spikes already committed this step.
  always_comb begin
    upd_current = '0;
    if (idx_q == IDX_IN0)       upd_current = cur_a_q;
    else if (idx_q == IDX_IN1)  upd_current = cur_b_q;
    else if (idx_q < IDX_OUT0)  upd_current = {spk_q[0], spk_q[1], 2'b00};
    else                        upd_current = {spk_q[2], spk_q[3], spk_q[4], spk_q[5]};
  end

  lif_update #(
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .state      (mem_q[idx_q]),
    .current    (upd_current),
    .thresh     (THRESH),
    .next_state (upd_next),
    .spike      (upd_spike)
  );

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    step_done = (state_q == DONE);
    unique case (state_q)
      IDLE:    if (step_start) state_d = RUN;
      RUN:     if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      spk_q      <= '0;
      cur_a_q    <= '0;
      cur_b_q    <= '0;
      hid_spikes <= '0;
      out_spikes <= '0;
      step_count <= '0;
      // NOTE: the membrane file is reset explicitly, since an aborted step must leave no residue.
      for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
          end
          if (step_start) begin
            cur_a_q <= cur_a;
            cur_b_q <= cur_b;
            idx_q   <= '0;
            spk_q   <= '0;
          end
        end
        RUN: begin
          mem_q[idx_q] <= upd_next;
          spk_q[idx_q] <= upd_spike;
          idx_q        <= idx_q + 3'd1;
        end
        DONE: begin
          hid_spikes <= spk_q[IDX_HID0 +: N_HID];
          out_spikes <= spk_q[IDX_OUT0 +: N_OUT];
          step_count <= step_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler against a per-step arithmetic model.
module tb_lif_step_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_start;
  logic       clear;
  logic [3:0] cur_a, cur_b;
  logic       busy, step_done;
  logic [1:0] out_spikes;
  logic [3:0] hid_spikes;
  logic [7:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_state [8];
  logic [3:0] m_hid;
  logic [1:0] m_out;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  lif_step_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_start (step_start),
    .cur_a      (cur_a),
    .cur_b      (cur_b),
    .clear      (clear),
    .busy       (busy),
    .step_done  (step_done),
    .out_spikes (out_spikes),
    .hid_spikes (hid_spikes),
    .step_count (step_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_state[i]) m_state[i] = 0;
    m_hid = '0;
    m_out = '0;
    m_cnt = '0;
  endfunction

  function automatic void model_clear();
    foreach (m_state[i]) m_state[i] = 0;
  endfunction

  // One timestep computed straight from the update rule, layer by layer.
  function automatic void model_step(input int ca, input int cb);
    int spk [8] = '{default: 0};
    int cur, sum, nxt;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)     cur = ca;
      else if (i == 1) cur = cb;
      else if (i < 6) cur = 8 * spk[0] + 4 * spk[1];
      else            cur = 8 * spk[2] + 4 * spk[3] + 2 * spk[4] + spk[5];
      sum = m_state[i] / 2 + cur;
      nxt = (sum > 15) ? 15 : sum;
      spk[i] = (nxt >= 8) ? 1 : 0;
      m_state[i] = (spk[i] != 0) ? 0 : nxt;
    end
    m_hid = 4'(spk[2] + 2 * spk[3] + 4 * spk[4] + 8 * spk[5]);
    m_out = 2'(spk[6] + 2 * spk[7]);
    m_cnt = m_cnt + 8'd1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_hid"}, hid_spikes, m_hid);
    check({tag, "_out"}, out_spikes, m_out);
    check({tag, "_cnt"}, step_count, m_cnt);
  endtask

  // Called at #1 after an edge with the DUT in IDLE.
  task automatic run_step(input logic [3:0] ca, input logic [3:0] cb, input bit clr, input bit poke);
    int n;
    cur_a = ca;
    cur_b = cb;
    clear = clr;
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    clear = 1'b0;
    if (clr) model_clear();
    check("busy_after_accept", busy, 1);
    n = 0;
    while (n < 20) begin
      if (poke && n == 3) begin
        step_start = 1'b1;
        clear = 1'b1;
      end else if (n == 4) begin
        step_start = 1'b0;
        clear = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (step_done) break;
    end
    step_start = 1'b0;
    clear = 1'b0;
    check("done_latency", n, 8);
    model_step(ca, cb);
    @(posedge clk); #1;
    check("busy_idle", busy, 0);
    check("done_pulse_end", step_done, 0);
    check_outputs("step");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic run_continuous(input int nsteps, input logic [3:0] ca, input logic [3:0] cb);
    int  cyc = 0, last = 0, dones = 0, idle = 0;
    bit  pending = 1'b0;
    cur_a = ca;
    cur_b = cb;
    step_start = 1'b1;
    while (cyc < nsteps * 10 + 40) begin
      @(posedge clk); #1;
      cyc++;
      if (pending) begin
        check("cont_busy_gap", busy, 0);
        check_outputs("cont");
        pending = 1'b0;
        if (dones == nsteps) break;
      end
      if (!busy) idle++;
      if (step_done) begin
        dones++;
        if (dones > 1) begin
          check("cont_period", cyc - last, 10);
          check("cont_idle", idle, 1);
        end
        last = cyc;
        idle = 0;
        model_step(ca, cb);
        pending = 1'b1;
        if (dones == nsteps) step_start = 1'b0;
      end
    end
    step_start = 1'b0;
    check("cont_steps", dones, nsteps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    step_start = 1'b0;
    clear = 1'b0;
    cur_a = '0;
    cur_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check_outputs("rst");

    // Zero-current step
    run_step(4'd0, 4'd0, 1'b0, 1'b0);
    check("first_cnt", step_count, 1);

    // Strong input on neuron 0 drives the whole network to fire
    run_step(4'd15, 4'd0, 1'b0, 1'b0);
    check("full_fire_hid", hid_spikes, 4'hF);
    check("full_fire_out", out_spikes, 2'b11);

    // cur_a = 5: 5, 7, then fire
    run_step(4'd5, 4'd0, 1'b0, 1'b0);
    check("c5_s1_hid", hid_spikes, 0);
    run_step(4'd5, 4'd0, 1'b0, 1'b0);
    check("c5_s2_hid", hid_spikes, 0);
    run_step(4'd5, 4'd0, 1'b0, 1'b0);
    check("c5_s3_hid", hid_spikes, 4'hF);

    // cur_a = 4: 4, 6, 7 never fires; third step pokes start/clear mid-RUN
    run_step(4'd4, 4'd0, 1'b0, 1'b0);
    run_step(4'd4, 4'd0, 1'b0, 1'b0);
    run_step(4'd4, 4'd0, 1'b0, 1'b1);
    check("c4_hid", hid_spikes, 0);
    do_clear();
    run_step(4'd4, 4'd0, 1'b0, 1'b0);
    // From state 4 a current of 5 stays below threshold; from 7 it would fire
    run_step(4'd5, 4'd0, 1'b0, 1'b0);
    check("after_clear_hid", hid_spikes, 0);

    // Randomised steps, occasionally with clear and mid-RUN pokes
    for (int i = 0; i < 30; i++) begin
      run_step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    // Back-to-back steps bring the total to 256, exercising the 255->0 wrap
    run_continuous(216, 4'd4, 4'd3);
    check("wrap_cnt", step_count, 0);

    // Abort at RUN index 3
    cur_a = 4'd4;
    cur_b = 4'd0;
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (step_done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_busy", busy, 0);
    check_outputs("abort");
    // From zeroed states a current of 7 cannot make neuron 0 fire
    run_step(4'd7, 4'd0, 1'b0, 1'b0);
    check("abort_probe_hid", hid_spikes, 0);
    check("abort_probe_cnt", step_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_step_scheduler.md
# lif_step_scheduler

Time-multiplexed controller for the 2-4-2 leaky-integrate-and-fire network. It stores all eight membrane states in one register file and shares a single LIF update datapath among them. On each `step_start` it updates neurons one per cycle in layer order (input, hidden, output), so each layer sees the spikes produced earlier in the same timestep. It sits between the top-level pins and the spike outputs, replacing eight parallel neuron instances with one sequenced engine.

## Interface
- `STATE_W`, 4: membrane state width; saturating.
- `THRESH`, 4'd8: fire when the post-update state is ≥ `THRESH`.
- `LEAK_SHIFT`, 1: leak is `state >> LEAK_SHIFT` on every update.

- `clk` in 1: the single clock; everything is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `step_start` in 1: request one timestep. Accepted only in IDLE.
- `cur_a` in 4: current for input neuron 0. Latched on accept.
- `cur_b` in 4: current for input neuron 1. Latched on accept.
- `clear` in 1: zeroes all membrane states. Honoured only in IDLE.
- `busy` out 1: high in RUN and DONE.
- `step_done` out 1: one-cycle pulse in DONE.
- `out_spikes` out 2: output-layer spikes of the last completed step. Registered and held until the next DONE.
- `hid_spikes` out 4: hidden-layer spikes of the last completed step. Same hold rule as `out_spikes`.
- `step_count` out 8: completed steps. Wraps 255→0.

## Operation
- Neuron index map: 0–1 input, 2–5 hidden, 6–7 output.
- Update rule, in the shared datapath:
  - `sum = (state >> LEAK_SHIFT) + current`, computed 5 bits wide.
  - `next = min(sum, 15)`.
  - `spike = next ≥ THRESH`.
  - If `spike`, the stored state becomes 0; otherwise it becomes `next`.
- Currents per neuron:
  - Neuron 0 gets `cur_a`; neuron 1 gets `cur_b` (latched values).
  - Hidden neurons 2–5 all get `{spk[0], spk[1], 2'b00}`, using this step's input spikes.
  - Output neurons 6–7 both get `{spk[2], spk[3], spk[4], spk[5]}`, using this step's hidden spikes.
- An internal 8-bit spike vector `spk` is cleared on entry to RUN and written at each neuron's index.
- FSM:
  - IDLE → RUN on `step_start`. This latches `cur_a`/`cur_b`, sets index to 0 and clears `spk`.
  - RUN updates neuron[index], then index+1. RUN → DONE after index 7.
  - DONE copies `spk[5:2]` to `hid_spikes` and `spk[7:6]` to `out_spikes`, increments `step_count`, pulses `step_done`, then → IDLE.
- `step_start` outside IDLE is ignored. It is not queued.
- `clear` outside IDLE is ignored.
- If `clear` and `step_start` are both high in IDLE, `clear` applies first, and the step then runs from zeroed states.
- Reset values: all outputs 0, all states 0, FSM in IDLE, index 0.
- Reset asserted mid-RUN or in DONE: the step is aborted, no `step_done`, `step_count` is not incremented, and all states are zeroed.

## Timing
- Accept at cycle T: `busy` = 1 from T+1.
- T+1..T+8: RUN, index 0..7.
- T+9: DONE. `step_done` = 1, and the new `out_spikes`/`hid_spikes`/`step_count` are visible from T+10.
- T+10: IDLE with `busy` = 0. The earliest next accept is T+10.
- Step period: 10 cycles with back-to-back `step_start`.
- A neuron's state update commits at the end of its RUN cycle. Later indices see its spike in the same step.

## Structure
- `lif_pkg` holds:
  - `STATE_W`.
  - The index constants `IDX_IN0`, `IDX_HID0`, `IDX_OUT0`, `N_NEURONS` = 8.
  - The FSM enum {IDLE, RUN, DONE}.
- Sub-module `lif_update`: combinational leak/integrate/saturate/fire. One shared instance, with inputs state, current, `THRESH` and outputs `next_state`, `spike`.
- Scheduler top holds the FSM, index counter, state register file (8×4), spike vector and output registers.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles → all outputs 0. Then `step_start` with `cur_a` = `cur_b` = 0 → `step_done` at T+9, `out_spikes` = 0, `hid_spikes` = 0, `step_count` = 1.
- `cur_a` = 15, `cur_b` = 0, one step:
  - Neuron 0 reaches 15 and fires; neuron 1 does not.
  - Hidden current is 8, so all four hidden neurons fire: `hid_spikes` = 4'hF.
  - Output current is 15, so `out_spikes` = 2'b11.
  - All fired states read back as 0.
- `cur_a` = 5 for consecutive steps: neuron 0 state goes 5, 7, then fires on step 3 (sum 8). `cur_a` = 4 instead: 4, 6, 7, 7, … and it never fires.
- `step_start` held high continuously → exactly one `step_done` every 10 cycles, `busy` low for one cycle between steps, and `step_count` wraps 255→0 after 256 steps.
- `step_start` and `clear` pulsed during RUN → both ignored and states unaffected. `clear` in IDLE after step 2 of the `cur_a` = 4 run → the next step shows state 4 again.
- `rst_n` = 0 at RUN index 3 → no `step_done`, `step_count` unchanged, FSM in IDLE, and all states 0 on the next step.
